// File: rtl/motor_speed_pi_pkg.sv
// Shared types and widths for the motor speed PI controller.
`timescale 1ns/1ps
package motor_speed_pi_pkg;

  localparam int unsigned MEAS_W   = 16;
  localparam int unsigned DUTY_W   = 10;
  localparam int unsigned DUTY_MAX = 1023;
  localparam int unsigned ERR_W    = 17;
  localparam int unsigned INTEG_W  = 24;
  localparam int unsigned PROD_W   = 40;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ERR  = 3'd1,
    ST_INT  = 3'd2,
    ST_MUL  = 3'd3,
    ST_SUM  = 3'd4,
    ST_OUT  = 3'd5
  } state_e;

endpackage

// File: rtl/motor_speed_pi_if.sv
// Command/measurement inputs and drive/status outputs of the speed loop.
`timescale 1ns/1ps
interface motor_speed_pi_if;
  import motor_speed_pi_pkg::*;

  logic              ctrl_en;
  logic [MEAS_W-1:0] target_speed;
  logic [MEAS_W-1:0] edge_in;
  logic [DUTY_W-1:0] duty_out;
  logic              upd_pulse;
  logic              sat_flag;
  logic              pwm_out;

  modport master (
    output ctrl_en, target_speed, edge_in,
    input  duty_out, upd_pulse, sat_flag, pwm_out
  );

  modport slave (
    input  ctrl_en, target_speed, edge_in,
    output duty_out, upd_pulse, sat_flag, pwm_out
  );
endinterface

// File: rtl/motor_pwm_gen.sv
// PWM generator: prescaler, 10-bit counter, period-aligned duty shadow.
`timescale 1ns/1ps
module motor_pwm_gen
  import motor_speed_pi_pkg::*;
#(
  parameter int unsigned PWM_DIV = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_out
);

  localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [PRE_W-1:0]  pre_q, pre_n;
  logic [DUTY_W-1:0] cnt_q, cnt_n;
  logic [DUTY_W-1:0] shadow_q, shadow_n;

  // Next counter values; shadow only reloads as the PWM counter wraps to 0
  always_comb begin
    pre_n    = pre_q + PRE_W'(1);
    cnt_n    = cnt_q;
    shadow_n = shadow_q;
    if (pre_q == PRE_W'(PWM_DIV - 1)) begin
      pre_n = '0;
      cnt_n = cnt_q + DUTY_W'(1);
      if (cnt_q == DUTY_W'(DUTY_MAX)) begin
        shadow_n = duty;
      end
    end
  end

  // Counter/shadow registers; output compares the values valid next cycle
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      pwm_out  <= 1'b0;
    end else begin
      pre_q    <= pre_n;
      cnt_q    <= cnt_n;
      shadow_q <= shadow_n;
      pwm_out  <= (cnt_n < shadow_n);
    end
  end

endmodule

// File: rtl/motor_speed_pi.sv
// Closed-loop motor speed PI controller with PWM drive.
// Optional: define SPEEDCTRL_ANTIWINDUP_EN to freeze the integrator while
// the previous output was clamped in the direction of the current error.
`timescale 1ns/1ps
module motor_speed_pi
  import motor_speed_pi_pkg::*;
#(
  parameter int unsigned CTRL_PERIOD   = 125000000,
  parameter int unsigned SAMPLE_OFFSET = 2,
  parameter int unsigned KP            = 4,
  parameter int unsigned KI            = 1,
  parameter int unsigned GAIN_SHIFT    = 4,
  parameter int unsigned INT_LIM       = 65535,
  parameter int unsigned PWM_DIV       = 6
) (
  input logic              clk,
  input logic              n_rst,
  motor_speed_pi_if.slave  bus
);

  localparam int unsigned CNT_W = (CTRL_PERIOD > 1) ? $clog2(CTRL_PERIOD) : 1;

  localparam logic signed [INTEG_W:0]   INT_LIM_P = (INTEG_W + 1)'(INT_LIM);
  localparam logic signed [INTEG_W:0]   INT_LIM_N = -INT_LIM_P;
  localparam logic signed [PROD_W-1:0]  KP_S      = PROD_W'(KP);
  localparam logic signed [PROD_W-1:0]  KI_S      = PROD_W'(KI);
  localparam logic signed [PROD_W-1:0]  U_MAX     = PROD_W'(DUTY_MAX);

  state_e state_q, state_n;

  logic [CNT_W-1:0]           per_cnt, per_cnt_n;
  logic                       sample_c;
  logic [MEAS_W-1:0]          meas_q, meas_n, tgt_q, tgt_n;
  logic signed [ERR_W-1:0]    err_q, err_n;
  logic signed [INTEG_W-1:0]  integ_q, integ_n;
  logic signed [INTEG_W:0]    isum_c, iclamp_c;
  logic signed [PROD_W-1:0]   p_q, p_n, i_q, i_n, u_q, u_n;
  logic [DUTY_W-1:0]          duty_q, duty_n;
  logic                       sat_q, sat_n, upd_q, upd_n;
  logic                       hold_c;
  logic                       pwm_w;

  // Period counter wraps at CTRL_PERIOD; sampling keys off the incoming value
  always_comb begin
    per_cnt_n = per_cnt + CNT_W'(1);
    if (per_cnt == CNT_W'(CTRL_PERIOD - 1)) begin
      per_cnt_n = '0;
    end
  end

  assign sample_c = (per_cnt_n == CNT_W'(SAMPLE_OFFSET));

  // Integrator sum with symmetric magnitude clamp
  assign isum_c = (INTEG_W + 1)'(integ_q) + (INTEG_W + 1)'(err_q);

  always_comb begin
    iclamp_c = isum_c;
    if (isum_c > INT_LIM_P) begin
      iclamp_c = INT_LIM_P;
    end else if (isum_c < INT_LIM_N) begin
      iclamp_c = INT_LIM_N;
    end
  end

`ifdef SPEEDCTRL_ANTIWINDUP_EN
  logic sat_hi_q;

  // Remembers which rail the last clamp hit
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sat_hi_q <= 1'b0;
    end else if (state_q == ST_OUT) begin
      sat_hi_q <= !u_q[PROD_W-1];
    end
  end

  assign hold_c = sat_q &&
                  (( sat_hi_q && !err_q[ERR_W-1] && (err_q != '0)) ||
                   (!sat_hi_q &&  err_q[ERR_W-1]));
`else
  assign hold_c = 1'b0;
`endif

  // FSM next state: one cycle per step after the sample point
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (sample_c) state_n = ST_ERR;
      ST_ERR:  state_n = ST_INT;
      ST_INT:  state_n = ST_MUL;
      ST_MUL:  state_n = ST_SUM;
      ST_SUM:  state_n = ST_OUT;
      ST_OUT:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // PI datapath next values, one stage per FSM state
  always_comb begin
    meas_n  = meas_q;
    tgt_n   = tgt_q;
    err_n   = err_q;
    integ_n = integ_q;
    p_n     = p_q;
    i_n     = i_q;
    u_n     = u_q;
    duty_n  = duty_q;
    sat_n   = sat_q;
    upd_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_c) begin
          meas_n = bus.edge_in;
          tgt_n  = bus.target_speed;
        end
      end
      ST_ERR: err_n = signed'(ERR_W'(tgt_q)) - signed'(ERR_W'(meas_q));
      ST_INT: integ_n = hold_c ? integ_q : INTEG_W'(iclamp_c);
      ST_MUL: begin
        p_n = KP_S * PROD_W'(err_q);
        i_n = KI_S * PROD_W'(integ_q);
      end
      ST_SUM: u_n = (p_q + i_q) >>> GAIN_SHIFT;
      ST_OUT: begin
        if (!bus.ctrl_en || (tgt_q == '0)) begin
          duty_n  = '0;
          sat_n   = 1'b0;
          integ_n = '0;
        end else if (u_q[PROD_W-1]) begin
          duty_n = '0;
          sat_n  = 1'b1;
        end else if (u_q > U_MAX) begin
          duty_n = DUTY_W'(DUTY_MAX);
          sat_n  = 1'b1;
        end else begin
          duty_n = DUTY_W'(u_q);
          sat_n  = 1'b0;
        end
        upd_n = (duty_n != duty_q);
      end
      default: ;
    endcase
  end

  // State, counter and datapath registers
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      per_cnt <= '0;
      meas_q  <= '0;
      tgt_q   <= '0;
      err_q   <= '0;
      integ_q <= '0;
      p_q     <= '0;
      i_q     <= '0;
      u_q     <= '0;
      duty_q  <= '0;
      sat_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      per_cnt <= per_cnt_n;
      meas_q  <= meas_n;
      tgt_q   <= tgt_n;
      err_q   <= err_n;
      integ_q <= integ_n;
      p_q     <= p_n;
      i_q     <= i_n;
      u_q     <= u_n;
      duty_q  <= duty_n;
      sat_q   <= sat_n;
      upd_q   <= upd_n;
    end
  end

  motor_pwm_gen #(
    .PWM_DIV (PWM_DIV)
  ) u_pwm (
    .clk     (clk),
    .n_rst   (n_rst),
    .duty    (duty_q),
    .pwm_out (pwm_w)
  );

  assign bus.duty_out  = duty_q;
  assign bus.upd_pulse = upd_q;
  assign bus.sat_flag  = sat_q;
  assign bus.pwm_out   = pwm_w;

endmodule

// File: tb/tb_motor_speed_pi.sv
// Directed bench for motor_speed_pi: per-period vector table plus PWM and
// reset sequences. Build with SPEEDCTRL_ANTIWINDUP_EN to match that variant.
`timescale 1ns/1ps
module tb_motor_speed_pi;

  typedef struct {
    logic [15:0] tgt;
    logic [15:0] meas;
    logic        en;
    logic        drop;
    int          duty;
    logic        sat;
    logic        upd;
  } vec_t;

`ifdef SPEEDCTRL_ANTIWINDUP_EN
  localparam int EXP7  = 312;
  localparam int EXP12 = 262;
`else
  localparam int EXP7  = 625;
  localparam int EXP12 = 212;
`endif

  localparam int NVEC = 18;

  logic clk = 1'b0;
  logic n_rst;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   pwm_hi[32];
  vec_t vecs[NVEC];

  motor_speed_pi_if bus();

  motor_speed_pi #(
    .CTRL_PERIOD   (1000),
    .SAMPLE_OFFSET (2),
    .KP            (4),
    .KI            (1),
    .GAIN_SHIFT    (4),
    .INT_LIM       (65535),
    .PWM_DIV       (1)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; equals the DUT period count within a period
  always @(posedge clk) begin
    if (!n_rst) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // High cycles per 1024-cycle PWM period (PWM_DIV=1)
  always @(negedge clk) begin
    if (n_rst === 1'b1 && cyc > 0 && (cyc / 1024) < 32)
      pwm_hi[cyc / 1024] += int'(bus.pwm_out);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic goto(input int k);
    int n;
    n = 0;
    while (cyc != k && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != k) chk($sformatf("goto_%0d", k), cyc, k);
  endtask

  task automatic run_vec(input int p, input vec_t v, input int prev);
    int base;
    base = 1000 * p;
    goto(base);
    bus.target_speed = v.tgt;
    bus.edge_in      = v.meas;
    bus.ctrl_en      = v.en;
    goto(base + 3);
    bus.target_speed = 16'hFFFF;
    bus.edge_in      = 16'hFFFF;
    if (v.drop) begin
      goto(base + 4);
      bus.ctrl_en = 1'b0;
    end
    goto(base + 6);
    chk($sformatf("p%0d_upd_early", p), int'(bus.upd_pulse), 0);
    chk($sformatf("p%0d_duty_hold", p), int'(bus.duty_out), prev);
    goto(base + 7);
    chk($sformatf("p%0d_duty", p), int'(bus.duty_out), v.duty);
    chk($sformatf("p%0d_sat", p), int'(bus.sat_flag), int'(v.sat));
    chk($sformatf("p%0d_upd", p), int'(bus.upd_pulse), int'(v.upd));
    goto(base + 8);
    chk($sformatf("p%0d_upd_late", p), int'(bus.upd_pulse), 0);
  endtask

  initial begin
    int prev;
    vecs[0]  = '{16'd1000, 16'd200,  1'b1, 1'b0, 250,   1'b0, 1'b1};
    vecs[1]  = '{16'd1000, 16'd200,  1'b1, 1'b0, 300,   1'b0, 1'b1};
    vecs[2]  = '{16'd1000, 16'd1000, 1'b1, 1'b0, 100,   1'b0, 1'b1};
    vecs[3]  = '{16'd1000, 16'd1100, 1'b1, 1'b0, 68,    1'b0, 1'b1};
    vecs[4]  = '{16'd1000, 16'd1000, 1'b0, 1'b0, 0,     1'b0, 1'b1};
    vecs[5]  = '{16'd5000, 16'd0,    1'b1, 1'b0, 1023,  1'b1, 1'b1};
    vecs[6]  = '{16'd5000, 16'd0,    1'b1, 1'b0, 1023,  1'b1, 1'b0};
    vecs[7]  = '{16'd1000, 16'd1000, 1'b1, 1'b0, EXP7,  1'b0, 1'b1};
    vecs[8]  = '{16'd0,    16'd500,  1'b1, 1'b0, 0,     1'b0, 1'b1};
    vecs[9]  = '{16'd100,  16'd900,  1'b1, 1'b0, 0,     1'b1, 1'b0};
    vecs[10] = '{16'd100,  16'd900,  1'b1, 1'b0, 0,     1'b1, 1'b0};
    vecs[11] = '{16'd1000, 16'd1000, 1'b1, 1'b0, 0,     1'b1, 1'b0};
    vecs[12] = '{16'd2000, 16'd1000, 1'b1, 1'b0, EXP12, 1'b0, 1'b1};
    vecs[13] = '{16'd2000, 16'd1000, 1'b1, 1'b1, 0,     1'b0, 1'b1};
    vecs[14] = '{16'd1000, 16'd200,  1'b1, 1'b0, 250,   1'b0, 1'b1};
    vecs[15] = '{16'd1679, 16'd200,  1'b1, 1'b0, 512,   1'b0, 1'b1};
    vecs[16] = '{16'd564,  16'd200,  1'b1, 1'b0, 256,   1'b0, 1'b1};
    vecs[17] = '{16'd491,  16'd200,  1'b1, 1'b0, 256,   1'b0, 1'b0};

    n_rst            = 1'b0;
    bus.ctrl_en      = 1'b0;
    bus.target_speed = '0;
    bus.edge_in      = '0;
    repeat (3) @(negedge clk);
    chk("rst_duty", int'(bus.duty_out), 0);
    chk("rst_sat",  int'(bus.sat_flag), 0);
    chk("rst_upd",  int'(bus.upd_pulse), 0);
    chk("rst_pwm",  int'(bus.pwm_out), 0);
    n_rst = 1'b1;

    prev = 0;
    for (int p = 0; p < NVEC; p++) begin
      run_vec(p, vecs[p], prev);
      prev = vecs[p].duty;
    end

    // PWM high counts per period: shadow adopts duty only at period start
    goto(17500);
    chk("pwm_per12", pwm_hi[12], EXP12);
    chk("pwm_per13_stopped", pwm_hi[13], 0);
    chk("pwm_per14", pwm_hi[14], 250);
    chk("pwm_per15_glitchfree", pwm_hi[15], 512);
    chk("pwm_per16", pwm_hi[16], 256);

    // One-cycle reset while the FSM is in SUM
    goto(18000);
    bus.target_speed = 16'd1000;
    bus.edge_in      = 16'd200;
    bus.ctrl_en      = 1'b1;
    goto(18005);
    n_rst = 1'b0;
    @(negedge clk);
    chk("midrst_duty", int'(bus.duty_out), 0);
    chk("midrst_sat",  int'(bus.sat_flag), 0);
    chk("midrst_upd",  int'(bus.upd_pulse), 0);
    chk("midrst_pwm",  int'(bus.pwm_out), 0);
    n_rst = 1'b1;
    run_vec(0, vecs[0], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/motor_speed_pi.md
# motor_speed_pi

Closed-loop speed controller for the drive motor. Sits directly downstream of the encoder edge counter: once per control period it samples the 16-bit edges-per-second count and compares it against a commanded target. A fixed-point PI law turns the difference into a 10-bit duty. A PWM stage drives the motor driver input from that duty.

## Interface
Parameters:
- CTRL_PERIOD, 125000000: control period in clk cycles; equals the edge counter's 1 s window.
- SAMPLE_OFFSET, 2: period-counter value at which `edge_in` is sampled.
- KP, 4: proportional gain, unsigned integer.
- KI, 1: integral gain, unsigned integer.
- GAIN_SHIFT, 4: arithmetic right shift applied to the PI sum.
- INT_LIM, 65535: integrator magnitude clamp.
- PWM_DIV, 6: PWM counter prescaler.

Ports:
- clk, in, 1: 125 MHz system clock.
- n_rst, in, 1: synchronous reset, active low.
- ctrl_en, in, 1: loop enable.
- target_speed, in, 16: commanded edges per second.
- edge_in, in, 16: measured edges per second from the edge counter.
- duty_out, out, 10: current duty, 0..1023.
- upd_pulse, out, 1: one-cycle strobe when `duty_out` changes value.
- sat_flag, out, 1: last computed output was clamped.
- pwm_out, out, 1: PWM drive.

Reset is synchronous and active-low on `n_rst`; everything runs on the single clock `clk`.

## Operation
- **Period counter:** runs 0..CTRL_PERIOD-1 and wraps. Its count is aligned from reset with the edge counter, so a sample taken at SAMPLE_OFFSET reads the freshly latched count.
- **FSM states:** IDLE, ERR, INT, MUL, SUM, OUT, one cycle each except IDLE.
- **IDLE:** leave when the counter equals SAMPLE_OFFSET. On exit, latch `edge_in` and `target_speed`.
- **ERR:** err = target − meas, 17-bit signed.
- **INT:** integ = clamp(integ + err, ±INT_LIM); integ is 24-bit signed.
- **MUL:** compute p = KP·err and i = KI·integ, both 40-bit signed.
- **SUM:** u = (p + i) >>> GAIN_SHIFT.
- **OUT:** clamp u to 0..1023, write `duty_out`, set `sat_flag` if the clamp was active, pulse `upd_pulse`. Return to IDLE.
- **Stop conditions:** if `ctrl_en`=0, or the latched target=0, OUT writes duty 0 and clears integ.
- **ctrl_en falling mid-sequence:** the FSM finishes the sequence, and OUT applies the stop rule.
- **PWM:** prescaler counts 0..PWM_DIV-1. The 10-bit PWM counter advances once per prescaler wrap.
  - pwm_out = (pwm_cnt < duty_shadow).
  - duty_shadow loads `duty_out` when pwm_cnt wraps to 0, so there are no mid-period glitches.
  - Duty 0 gives constant low. Duty 1023 gives high for 1023 of 1024 counts.

## Timing
- **Reset values:** duty_out=0, upd_pulse=0, sat_flag=0, pwm_out=0, integ=0, FSM=IDLE, all counters 0.
- **Latency:** `edge_in` is sampled at counter=SAMPLE_OFFSET, and `duty_out` and `upd_pulse` are valid at counter=SAMPLE_OFFSET+5.
- **PWM adoption:** the new duty reaches `pwm_out` at the next PWM period start, at most 1024·PWM_DIV cycles later.
- **Input sensitivity:** changes to `edge_in` or `target_speed` outside the sample cycle have no effect.
- **Reset mid-sequence:** n_rst low in any state returns to reset values on the next edge. No partial duty write occurs.

## Configuration
- **SPEEDCTRL_ANTIWINDUP_EN defined:** in INT, the integrator holds its value when the previous OUT saturated high with err>0, or saturated low with err<0. Otherwise the clamp is applied as usual.
- **Undefined:** the integrator always accumulates, limited only by INT_LIM.

## Structure
- **Shared package:** FSM state encoding, DUTY_W=10, DUTY_MAX=1023, the err width (17) and the integ width (24).
- **Sub-module `motor_pwm_gen`:** prescaler, PWM counter, duty shadow register and comparator. Inputs are clk, n_rst and duty; output is pwm_out.
- The PI datapath and FSM stay in the top module.

## Test plan
Bench settings: CTRL_PERIOD=1000, KP=4, KI=1, GAIN_SHIFT=4, PWM_DIV=1.
- **Basic update:** target=1000, edge_in=200, first period → err=800, integ=800, u=(3200+800)>>4=250. duty_out=250 at count 7, with a single upd_pulse.
- **High saturation:** target=5000, edge_in=0 → u=(20000+5000)>>4=1562 clamps to duty 1023 and sat_flag=1. With SPEEDCTRL_ANTIWINDUP_EN, integ stays at 5000 in the next period. Without it, integ reaches 10000.
- **Low saturation:** target=100, edge_in=900 → negative u clamps to duty 0 and sat_flag=1.
- **Enable drop:** ctrl_en=0 during MUL → duty 0 at OUT, integ=0, and pwm_out is low from the next PWM period.
- **Glitch-free duty change:** duty changes from 512 to 256 mid-PWM-period → the current period stays high for 512 counts, and the next period is high for 256.
- **Reset mid-sequence:** n_rst low for one cycle in SUM → all outputs 0 and no upd_pulse. The loop resumes normally in the following period.
